// File: rtl/cga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cga_pkg
// Brief   : Shared types and defaults for the CGA VRAM arbiter slice.
// Revision: 1.0
// ============================================================================
package cga_pkg;

   localparam int c_ADDR_W_DEFAULT = 14;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_A2   = 3'd2,
      ST_A3   = 3'd3,
      ST_DONE = 3'd4
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/cga_vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : cga_vram_arbiter_if
// Brief   : CPU (ISA) request/acknowledge bus into the VRAM arbiter.
// Revision: 1.0
// ============================================================================
interface cga_vram_arbiter_if
   import cga_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W_DEFAULT
);
   logic              cpu_req;
   logic              cpu_rdy;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic              cpu_ack;
   logic [7:0]        cpu_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdy, cpu_ack, cpu_rdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdy, cpu_ack, cpu_rdata
   );
endinterface
`default_nettype wire

// File: rtl/cga_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cga_vram_arbiter
// Brief   : Shares the single-ported VRAM between display fetch and CPU access.
// Revision: 1.0
// ============================================================================
module cga_vram_arbiter
   import cga_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W_DEFAULT
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              vram_read,
   input  wire logic              vram_read_a0,
   input  wire logic              vram_read_char,
   input  wire logic              vram_read_att,
   input  wire logic              isa_op_enable,
   input  wire logic [ADDR_W-2:0] disp_addr,
   cga_vram_arbiter_if.slave      cpu,
   output logic      [ADDR_W-1:0] ram_a,
   output logic                   ram_we,
   output logic      [7:0]        ram_d,
   input  wire logic [7:0]        ram_q,
   output logic      [7:0]        char_byte,
   output logic      [7:0]        attr_byte,
   output logic                   conflict
);

   arb_state_t        r_state;
   arb_state_t        w_next;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_wdata;
   logic [7:0]        r_rdata;
   logic [7:0]        r_char;
   logic [7:0]        r_attr;
   logic              r_conflict;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (cpu.cpu_req) w_next = ST_WAIT;
         ST_WAIT: if (isa_op_enable) w_next = ST_A2;
         ST_A2:   w_next = ST_A3;
         ST_A3:   w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 8'h00;
         r_rdata    <= 8'h00;
         r_char     <= 8'h00;
         r_attr     <= 8'h00;
         r_conflict <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && cpu.cpu_req) begin
            r_we    <= cpu.cpu_we;
            r_addr  <= cpu.cpu_addr;
            r_wdata <= cpu.cpu_wdata;
         end
         // RAM output during A3 carries the byte addressed in A2.
         if (r_state == ST_A3 && !r_we) begin
            r_rdata <= ram_q;
         end
         if (vram_read_char) begin
            r_char <= ram_q;
         end
         if (vram_read_att) begin
            r_attr <= ram_q;
         end
         if (vram_read && (r_state == ST_A2 || r_state == ST_A3)) begin
            r_conflict <= 1'b1;
         end
      end
   end

   // Display fetch always wins the port; DONE needs no port at all.
   assign ram_a         = vram_read ? {disp_addr, vram_read_a0} : r_addr;
   assign ram_we        = (r_state == ST_A2) && r_we && !vram_read;
   assign ram_d         = r_wdata;

   assign cpu.cpu_rdy   = (r_state == ST_IDLE);
   assign cpu.cpu_ack   = (r_state == ST_DONE);
   assign cpu.cpu_rdata = r_rdata;

   assign char_byte     = r_char;
   assign attr_byte     = r_attr;
   assign conflict      = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_cga_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cga_vram_arbiter
// Brief   : Self-checking bench: sequencer model, sync RAM, table and random CPU traffic.
// Revision: 1.0
// ============================================================================
module tb_cga_vram_arbiter;
   import cga_pkg::*;

   localparam int c_AW = 14;

   logic            clk = 1'b0;
   logic            reset;
   logic [4:0]      clk_seq = 5'd0;
   logic            force_read;
   logic [c_AW-2:0] disp_addr;
   logic            vram_read, vram_read_a0, vram_read_char, vram_read_att, isa_op_enable;
   logic [c_AW-1:0] ram_a;
   logic            ram_we;
   logic [7:0]      ram_d, ram_q, char_byte, attr_byte;
   logic            conflict;

   cga_vram_arbiter_if #(.ADDR_W(c_AW)) cpu_if ();

   cga_vram_arbiter #(.ADDR_W(c_AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .vram_read      (vram_read),
      .vram_read_a0   (vram_read_a0),
      .vram_read_char (vram_read_char),
      .vram_read_att  (vram_read_att),
      .isa_op_enable  (isa_op_enable),
      .disp_addr      (disp_addr),
      .cpu            (cpu_if),
      .ram_a          (ram_a),
      .ram_we         (ram_we),
      .ram_d          (ram_d),
      .ram_q          (ram_q),
      .char_byte      (char_byte),
      .attr_byte      (attr_byte),
      .conflict       (conflict)
   );

   always #5 clk = ~clk;

   // Sequencer model: display fetch at 1..3 / 17..19, CPU windows 5..14 / 21..30.
   always @(posedge clk) clk_seq <= clk_seq + 5'd1;

   function automatic bit en_slot(int k);
      return (k >= 5 && k <= 14) || (k >= 21 && k <= 30);
   endfunction

   assign vram_read      = (clk_seq == 5'd1) || (clk_seq == 5'd2) || (clk_seq == 5'd17) ||
                           (clk_seq == 5'd18) || force_read;
   assign vram_read_a0   = (clk_seq == 5'd2) || (clk_seq == 5'd18);
   assign vram_read_char = (clk_seq == 5'd2) || (clk_seq == 5'd18);
   assign vram_read_att  = (clk_seq == 5'd3) || (clk_seq == 5'd19);
   assign isa_op_enable  = en_slot(int'(clk_seq));

   // Initial VRAM contents, used by both the RAM and the reference model.
   function automatic logic [7:0] pat(logic [c_AW-1:0] a);
      case (a)
         14'h0100: return 8'h41;
         14'h0101: return 8'h1F;
         14'h0201: return 8'hC3;
         default:  return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hA5;
      endcase
   endfunction

   bit [7:0] mem [0:(1<<c_AW)-1];
   bit       vld [0:(1<<c_AW)-1];

   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_a] <= ram_d;
         vld[ram_a] <= 1'b1;
      end
      ram_q <= vld[ram_a] ? mem[ram_a] : pat(ram_a);
   end

   function automatic logic [7:0] ram_peek(logic [c_AW-1:0] a);
      return vld[a] ? mem[a] : pat(a);
   endfunction

   int              we_cnt = 0;
   logic [c_AW-1:0] we_a;
   logic [7:0]      we_d;
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         we_cnt <= we_cnt + 1;
         we_a   <= ram_a;
         we_d   <= ram_d;
      end
   end

   // Reference model: memory image and latency from the window rules.
   bit [7:0] ref_mem [0:(1<<c_AW)-1];
   bit       ref_vld [0:(1<<c_AW)-1];

   function automatic logic [7:0] ref_rd(logic [c_AW-1:0] a);
      return ref_vld[a] ? ref_mem[a] : pat(a);
   endfunction

   function automatic int model_lat(int s);
      int c;
      c = s + 1;
      while (!en_slot(c % 32)) c++;
      return c + 3 - s;
   endfunction

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_seq(logic [4:0] k);
      for (int i = 0; i < 70; i++) begin
         if (clk_seq == k) return;
         step();
      end
      chk("wait_seq_timeout", 32'(clk_seq), 32'(k));
   endtask

   task automatic run_txn(input logic we, input logic [c_AW-1:0] a, input logic [7:0] wd,
                          output int lat, output logic [7:0] rd, output int npulse);
      int base;
      base = we_cnt;
      chk("rdy_before_req", 32'(cpu_if.cpu_rdy), 32'd1);
      cpu_if.cpu_req   = 1'b1;
      cpu_if.cpu_we    = we;
      cpu_if.cpu_addr  = a;
      cpu_if.cpu_wdata = wd;
      step();
      cpu_if.cpu_req   = 1'b0;
      cpu_if.cpu_we    = 1'b0;
      cpu_if.cpu_wdata = 8'h00;
      lat = 1;
      while (cpu_if.cpu_ack !== 1'b1 && lat < 80) begin
         step();
         lat++;
      end
      if (lat >= 80) begin
         n_cmp++;
         n_err++;
         $display("FAIL ack_timeout: no cpu_ack within %0d cycles, addr 0x%0h", lat, a);
      end
      rd = cpu_if.cpu_rdata;
      chk("rdy_low_in_done", 32'(cpu_if.cpu_rdy), 32'd0);
      step();
      chk("ack_one_cycle", 32'(cpu_if.cpu_ack), 32'd0);
      chk("rdy_after_done", 32'(cpu_if.cpu_rdy), 32'd1);
      npulse = we_cnt - base;
   endtask

   typedef struct {
      logic [4:0]      req_seq;
      logic            we;
      logic [c_AW-1:0] addr;
      logic [7:0]      wdata;
      int              exp_lat;
      logic [7:0]      exp_rdata;
   } vec_t;

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t            tbl [6];
      int              lat, np, base, acks, exp_lat;
      logic [7:0]      rd, last_rd;
      logic            we;
      logic [c_AW-1:0] a;
      logic [7:0]      wd;

      tbl[0] = '{5'd20, 1'b1, 14'h0200, 8'h5A, 4,  8'h00};
      tbl[1] = '{5'd1,  1'b0, 14'h0201, 8'h00, 7,  8'hC3};
      tbl[2] = '{5'd13, 1'b0, 14'h0200, 8'h00, 4,  8'h5A};
      tbl[3] = '{5'd30, 1'b1, 14'h3FFF, 8'hA5, 10, 8'h5A};
      tbl[4] = '{5'd29, 1'b0, 14'h3FFF, 8'h00, 4,  8'hA5};
      tbl[5] = '{5'd14, 1'b0, 14'h0100, 8'h00, 10, 8'h41};

      reset            = 1'b1;
      force_read       = 1'b0;
      disp_addr        = 13'h0080;
      cpu_if.cpu_req   = 1'b0;
      cpu_if.cpu_we    = 1'b0;
      cpu_if.cpu_addr  = '0;
      cpu_if.cpu_wdata = 8'h00;
      repeat (3) step();
      chk("rst_rdy", 32'(cpu_if.cpu_rdy), 32'd1);
      chk("rst_ack", 32'(cpu_if.cpu_ack), 32'd0);
      chk("rst_rdata", 32'(cpu_if.cpu_rdata), 32'h00);
      chk("rst_char", 32'(char_byte), 32'h00);
      chk("rst_attr", 32'(attr_byte), 32'h00);
      chk("rst_conflict", 32'(conflict), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step();

      // Display fetch of word 0x080 -> bytes 0x100/0x101.
      wait_seq(5'd0);
      wait_seq(5'd4);
      chk("disp_char", 32'(char_byte), 32'h41);
      chk("disp_attr", 32'(attr_byte), 32'h1F);

      // Table of CPU accesses at chosen sequencer phases; second fetch uses word 0x0A0.
      disp_addr = 13'h00A0;
      for (int i = 0; i < 6; i++) begin
         wait_seq(tbl[i].req_seq);
         run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd, np);
         chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
         chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rdata));
         chk($sformatf("tbl%0d_we_pulses", i), 32'(np), 32'(tbl[i].we));
         if (tbl[i].we) begin
            chk($sformatf("tbl%0d_we_addr", i), 32'(we_a), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_we_data", i), 32'(we_d), 32'(tbl[i].wdata));
            chk($sformatf("tbl%0d_ram", i), 32'(ram_peek(tbl[i].addr)), 32'(tbl[i].wdata));
            ref_mem[tbl[i].addr] = tbl[i].wdata;
            ref_vld[tbl[i].addr] = 1'b1;
         end
         wait_seq(5'd20);
         chk($sformatf("tbl%0d_hres_char", i), 32'(char_byte), 32'(ref_rd(14'h0140)));
         chk($sformatf("tbl%0d_hres_attr", i), 32'(attr_byte), 32'(ref_rd(14'h0141)));
      end
      chk("tbl_conflict", 32'(conflict), 32'd0);
      last_rd = 8'h41;

      // Randomized traffic against the reference model.
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 35)) step();
         we = 1'($urandom_range(0, 1));
         a  = 14'h0300 + 14'($urandom_range(0, 31));
         wd = 8'($urandom);
         exp_lat = model_lat(int'(clk_seq));
         run_txn(we, a, wd, lat, rd, np);
         chk("rnd_lat", 32'(lat), 32'(exp_lat));
         if (we) begin
            ref_mem[a] = wd;
            ref_vld[a] = 1'b1;
            chk("rnd_we_pulses", 32'(np), 32'd1);
            chk("rnd_we_addr", 32'(we_a), 32'(a));
            chk("rnd_we_data", 32'(we_d), 32'(wd));
         end else begin
            last_rd = ref_rd(a);
            chk("rnd_we_pulses", 32'(np), 32'd0);
         end
         chk("rnd_rdata", 32'(rd), 32'(last_rd));
         wait_seq(5'd0);
         disp_addr = 13'h0180 + 13'($urandom_range(0, 15));
         wait_seq(5'd4);
         chk("rnd_char", 32'(char_byte), 32'(ref_rd({disp_addr, 1'b0})));
         chk("rnd_attr", 32'(attr_byte), 32'(ref_rd({disp_addr, 1'b1})));
      end
      chk("rnd_conflict", 32'(conflict), 32'd0);

      // Display fetch forced into A2 of a write: write suppressed, conflict sticks.
      base = we_cnt;
      wait_seq(5'd5);
      cpu_if.cpu_req   = 1'b1;
      cpu_if.cpu_we    = 1'b1;
      cpu_if.cpu_addr  = 14'h0223;
      cpu_if.cpu_wdata = 8'h77;
      step();
      cpu_if.cpu_req = 1'b0;
      step();
      force_read = 1'b1;
      #1;
      chk("conf_ram_we", 32'(ram_we), 32'd0);
      chk("conf_ram_a", 32'(ram_a), 32'({disp_addr, 1'b0}));
      step();
      force_read = 1'b0;
      chk("conf_set", 32'(conflict), 32'd1);
      step();
      chk("conf_ack", 32'(cpu_if.cpu_ack), 32'd1);
      repeat (40) step();
      chk("conf_sticky", 32'(conflict), 32'd1);
      chk("conf_no_write", 32'(ram_peek(14'h0223)), 32'(ref_rd(14'h0223)));
      chk("conf_we_pulses", 32'(we_cnt - base), 32'd0);

      // Reset while a write sits in A2.
      base = we_cnt;
      wait_seq(5'd5);
      cpu_if.cpu_req   = 1'b1;
      cpu_if.cpu_we    = 1'b1;
      cpu_if.cpu_addr  = 14'h0222;
      cpu_if.cpu_wdata = 8'h99;
      step();
      cpu_if.cpu_req = 1'b0;
      step();
      chk("mid_we_in_a2", 32'(ram_we), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_ram_we", 32'(ram_we), 32'd0);
      chk("mid_rdy", 32'(cpu_if.cpu_rdy), 32'd1);
      chk("mid_ack", 32'(cpu_if.cpu_ack), 32'd0);
      chk("mid_rdata", 32'(cpu_if.cpu_rdata), 32'h00);
      chk("mid_char", 32'(char_byte), 32'h00);
      chk("mid_attr", 32'(attr_byte), 32'h00);
      chk("mid_conflict", 32'(conflict), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      acks = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (cpu_if.cpu_ack === 1'b1) acks++;
      end
      chk("mid_no_ack", 32'(acks), 32'd0);
      chk("mid_rdy_after", 32'(cpu_if.cpu_rdy), 32'd1);
      chk("mid_write_dropped", 32'(ram_peek(14'h0222)), 32'(ref_rd(14'h0222)));
      chk("mid_we_pulses", 32'(we_cnt - base), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
